fifo_drain_ctrl: RTL and testbench

Read-side controller that drains a `simple_fifo`-style buffer (registered data output, combinational `empty`) and presents the words downstream on a valid/ready stream. It issues `fifo_read_en` only when the FIFO reports non-empty and local space is guaranteed, captures the FIFO's registered output one cycle later into a 2-entry skid buffer, and counts delivered words. It sits between the FIFO read port and any back-pressuring consumer.

---
 rtl/fifo_drain_ctrl.sv | 106 ++++++++++
 tb/tb_fifo_drain_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_drain_ctrl
//
// Read-side controller for a FIFO with a registered data output and a
// combinational empty flag. A read is requested only when the FIFO has data
// and the local 2-entry skid buffer is guaranteed to have room for it, counting
// the word still in flight. The word returned one cycle after the read is
// captured into the skid buffer, which is presented on a valid/ready stream.
// Every word accepted downstream increments a wrapping counter.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         1 = new FIFO reads may be issued
//   i_fifo_empty     FIFO empty flag
//   o_fifo_read_en   FIFO read request (combinational)
//   i_fifo_data      FIFO registered output, valid the cycle after a read
//   o_out_valid      o_out_data holds a word
//   i_out_ready      consumer accepts the word this cycle
//   o_out_data       head of the skid buffer
//   o_words_drained  count of words accepted downstream (wraps)
//   o_busy           read in flight or buffer non-empty
// ---------------------------------------------------------------------------
module fifo_drain_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_read_en,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [CNT_WIDTH-1:0]  o_words_drained,
  output logic                  o_busy
);

  logic                  r_pend;           // read issued last cycle
  logic [1:0]            r_occ;            // skid-buffer occupancy, 0..2
  logic                  r_head;
  logic                  r_tail;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic [CNT_WIDTH-1:0]  r_words_drained;

  logic                  w_room;
  logic                  w_push;
  logic                  w_pop;

  // Room is judged on registered state only: a word still in flight already
  // owns a slot, and a pop this cycle is deliberately not credited.
  assign w_room = ({1'b0, r_occ} + {2'b00, r_pend}) < 3'd2;

  // Reset gates the request combinationally so the FIFO never sees a read
  // while the controller is held in reset.
  assign o_fifo_read_en  = i_rst_n & i_enable & ~i_fifo_empty & w_room;

  assign w_push          = r_pend;
  assign w_pop           = o_out_valid & i_out_ready;

  assign o_out_valid     = (r_occ != 2'd0);
  assign o_out_data      = r_mem[r_head];
  assign o_busy          = r_pend | (r_occ != 2'd0);
  assign o_words_drained = r_words_drained;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend          <= 1'b0;
      r_occ           <= 2'd0;
      r_head          <= 1'b0;
      r_tail          <= 1'b0;
      r_words_drained <= '0;
    end else begin
      r_pend <= o_fifo_read_en;

      if (w_push) begin
        r_tail <= ~r_tail;
      end

      if (w_pop) begin
        r_head          <= ~r_head;
        r_words_drained <= r_words_drained + 1'b1;
      end

      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // NOTE: the data storage has no reset; the occupancy count alone decides
  // whether an entry is meaningful, so clearing the words would buy nothing.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_drain_ctrl
//
// The driver models the FIFO as a queue of words: a sampled read request pops
// the oldest word, presents it on i_fifo_data after the edge, and pushes it as
// the expected downstream word. The monitor works from transaction counts
// only: words requested minus words accepted is what the controller holds or
// has in flight, which fixes the expected request, valid, busy and counter.
// ---------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic          i_fifo_empty;
  logic          o_fifo_read_en;
  logic [DW-1:0] i_fifo_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_out_data;
  logic [CW-1:0] o_words_drained;
  logic          o_busy;

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (i_enable),
    .i_fifo_empty    (i_fifo_empty),
    .o_fifo_read_en  (o_fifo_read_en),
    .i_fifo_data     (i_fifo_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_words_drained (o_words_drained),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q [$];   // contents of the modelled FIFO
  logic [DW-1:0] exp_q  [$];   // words read from the FIFO, in order
  logic          gate = 1'b0;  // forces the FIFO to look empty

  // Monitor bookkeeping
  int   issued  = 0;           // reads requested in earlier cycles
  int   popped  = 0;           // words accepted in earlier cycles
  logic last_rd = 1'b0;        // read requested in the previous cycle

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    int outstanding;
    int occ;
    if (!rst_n) begin
      check("rst_read_en", o_fifo_read_en, 0);
      check("rst_valid",   o_out_valid, 0);
      check("rst_busy",    o_busy, 0);
      check("rst_count",   o_words_drained, 0);
      issued  = 0;
      popped  = 0;
      last_rd = 1'b0;
      exp_q.delete();
    end else begin
      outstanding = issued - popped;
      occ         = outstanding - int'(last_rd);
      check("read_en", o_fifo_read_en,
            i_enable && !i_fifo_empty && (outstanding < 2));
      check("out_valid", o_out_valid, occ > 0);
      check("busy", o_busy, outstanding > 0);
      check("words_drained", o_words_drained, popped % 256);
      if (occ > 0) begin
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else                   check("out_data", o_out_data, exp_q[0]);
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      if (o_fifo_read_en) issued++;
      check("in_flight_le_2", (issued - popped) <= 2, 1);
      last_rd = o_fifo_read_en;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic load(input int n, input logic rnd, input logic [DW-1:0] w0,
                      input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                      input logic [DW-1:0] w3);
    logic [DW-1:0] fixed [4];
    fixed[0] = w0; fixed[1] = w1; fixed[2] = w2; fixed[3] = w3;
    for (int i = 0; i < n; i++) begin
      if (rnd || i >= 4) fifo_q.push_back(DW'($urandom_range(0, 15)));
      else               fifo_q.push_back(fixed[i]);
    end
    i_fifo_empty = (fifo_q.size() == 0) || gate;
  endtask

  // One clock: sample the request mid-cycle, then act as the FIFO after the edge.
  task automatic step(output logic rd);
    logic [DW-1:0] w;
    @(negedge clk);
    rd = o_fifo_read_en;
    @(posedge clk);
    #1;
    if (rd) begin
      if (fifo_q.size() == 0) begin
        check("fifo_underflow", 1, 0);
      end else begin
        w = fifo_q.pop_front();
        i_fifo_data = w;
        exp_q.push_back(w);
      end
    end
    i_fifo_empty = (fifo_q.size() == 0) || gate;
  endtask

  task automatic wait_idle(input int budget, input logic toggle_ready);
    logic rd;
    int   n = 0;
    while (!(fifo_q.size() == 0 && !o_busy && exp_q.size() == 0)) begin
      if (n == budget) begin
        check("idle_timeout", 1, 0);
        break;
      end
      step(rd);
      if (toggle_ready) i_out_ready = ~i_out_ready;
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic rd;
    int   p0;
    int   stall_reads;
    int   n;

    rst_n        = 1'b0;
    i_enable     = 1'b1;
    i_out_ready  = 1'b1;
    i_fifo_data  = '0;
    i_fifo_empty = 1'b1;
    #2;
    check("reset_read_en", o_fifo_read_en, 0);
    check("reset_valid",   o_out_valid, 0);
    check("reset_busy",    o_busy, 0);
    check("reset_count",   o_words_drained, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic drain
    @(posedge clk); #1;
    load(4, 1'b0, 4'd8, 4'd12, 4'd4, 4'd7);
    wait_idle(50, 1'b0);
    check("basic_count", o_words_drained, 4);
    check("basic_busy", o_busy, 0);

    // Back-pressure: only two reads may be outstanding during the stall
    i_out_ready = 1'b0;
    load(8, 1'b1, '0, '0, '0, '0);
    stall_reads = 0;
    repeat (10) begin
      step(rd);
      stall_reads += int'(rd);
    end
    check("stall_reads", stall_reads, 2);
    check("stall_valid", o_out_valid, 1);
    i_out_ready = 1'b1;
    wait_idle(60, 1'b0);
    check("bp_count", o_words_drained, 12);

    // Enable gating: drop enable right after the first read
    p0 = popped;
    load(5, 1'b1, '0, '0, '0, '0);
    n = 0;
    do begin
      step(rd);
      n++;
    end while (!rd && n < 10);
    check("gate_first_read", rd, 1);
    i_enable = 1'b0;
    repeat (6) step(rd);
    check("gate_delivered", popped - p0, 1);
    check("gate_fifo_left", fifo_q.size(), 4);
    i_enable = 1'b1;
    wait_idle(60, 1'b0);
    check("gate_total", popped - p0, 5);

    // Alternating ready
    p0 = popped;
    load(6, 1'b1, '0, '0, '0, '0);
    wait_idle(80, 1'b1);
    i_out_ready = 1'b1;
    check("alt_total", popped - p0, 6);
    check("alt_count", o_words_drained, 23);

    // Random traffic, long enough to wrap the counter
    load(260, 1'b1, '0, '0, '0, '0);
    n = 0;
    while (fifo_q.size() != 0 && n < 4000) begin
      i_enable     = ($urandom_range(0, 9) != 0);
      i_out_ready  = ($urandom_range(0, 3) != 0);
      gate         = ($urandom_range(0, 7) == 0);
      i_fifo_empty = (fifo_q.size() == 0) || gate;
      step(rd);
      n++;
    end
    check("random_fifo_drained", fifo_q.size(), 0);
    gate = 1'b0; i_enable = 1'b1; i_out_ready = 1'b1;
    i_fifo_empty = (fifo_q.size() == 0);
    wait_idle(20, 1'b0);
    check("wrap_count", o_words_drained, (23 + 260) % 256);

    // Reset mid-operation with the buffer full
    i_out_ready = 1'b0;
    load(4, 1'b1, '0, '0, '0, '0);
    repeat (4) step(rd);
    check("pre_reset_valid", o_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_read_en", o_fifo_read_en, 0);
    check("async_valid",   o_out_valid, 0);
    check("async_busy",    o_busy, 0);
    check("async_count",   o_words_drained, 0);
    repeat (3) step(rd);
    #2 rst_n = 1'b1;
    i_out_ready = 1'b1;
    wait_idle(40, 1'b0);
    check("post_reset_count", o_words_drained, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
